// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared ALU ops, forward selects and pipelined control record
package pipe_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    // Branch/Jump resolve in D, so only the downstream control travels on.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       alu_src;
        logic       reg_dst;
        logic [2:0] alu_ctrl;
    } ctrl_t;

endpackage

// File: rtl/pipe_hazard.sv
// rtl/pipe_hazard.sv - combinational stall, flush and forward generation
module pipe_hazard
    import pipe_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] i_rs_D,
    input  logic [AW-1:0] i_rt_D,
    input  logic [AW-1:0] i_rs_E,
    input  logic [AW-1:0] i_rt_E,
    input  logic [AW-1:0] i_wreg_E,
    input  logic [AW-1:0] i_wreg_M,
    input  logic [AW-1:0] i_wreg_W,
    input  logic          i_branch_D,
    input  logic          i_jump_D,
    input  logic          i_eq_D,
    input  logic          i_reg_write_E,
    input  logic          i_mem_to_reg_E,
    input  logic          i_reg_write_M,
    input  logic          i_mem_to_reg_M,
    input  logic          i_mem_access_M,
    input  logic          i_reg_write_W,
    input  logic          i_dmem_ready_M,
    output logic [1:0]    o_fwd_a_E,
    output logic [1:0]    o_fwd_b_E,
    output logic          o_fwd_a_D,
    output logic          o_fwd_b_D,
    output logic          o_mem_wait,
    output logic          o_hold_F,
    output logic          o_bubble_E,
    output logic          o_redirect_D
);

    logic w_lw_stall;
    logic w_br_stall;

    function automatic logic hit(input logic en, input logic [AW-1:0] dst, input logic [AW-1:0] src);
        return en && (dst == src) && (src != '0);
    endfunction

    assign o_fwd_a_E = hit(i_reg_write_M, i_wreg_M, i_rs_E) ? FWD_M :
                       hit(i_reg_write_W, i_wreg_W, i_rs_E) ? FWD_W : FWD_REG;
    assign o_fwd_b_E = hit(i_reg_write_M, i_wreg_M, i_rt_E) ? FWD_M :
                       hit(i_reg_write_W, i_wreg_W, i_rt_E) ? FWD_W : FWD_REG;
    assign o_fwd_a_D = hit(i_reg_write_M, i_wreg_M, i_rs_D);
    assign o_fwd_b_D = hit(i_reg_write_M, i_wreg_M, i_rt_D);

    assign w_lw_stall = i_mem_to_reg_E && !i_jump_D &&
                        (hit(i_reg_write_E, i_wreg_E, i_rs_D) || hit(i_reg_write_E, i_wreg_E, i_rt_D));
    // A load still in M cannot feed the comparator, only ALU results can.
    assign w_br_stall = i_branch_D &&
                        (hit(i_reg_write_E, i_wreg_E, i_rs_D) || hit(i_reg_write_E, i_wreg_E, i_rt_D) ||
                         hit(i_reg_write_M && i_mem_to_reg_M, i_wreg_M, i_rs_D) ||
                         hit(i_reg_write_M && i_mem_to_reg_M, i_wreg_M, i_rt_D));

    assign o_mem_wait   = i_mem_access_M && !i_dmem_ready_M;
    assign o_hold_F     = o_mem_wait || w_lw_stall || w_br_stall;
    assign o_bubble_E   = !o_mem_wait && (w_lw_stall || w_br_stall);
    assign o_redirect_D = !o_hold_F && (i_jump_D || (i_branch_D && i_eq_D));

endmodule

// File: rtl/pipe_datapath_hz.sv
// rtl/pipe_datapath_hz.sv - five-stage integer datapath with hazard unit and memory wait
module pipe_datapath_hz
    import pipe_pkg::*;
#(
    parameter int            DW       = 32,
    parameter int            NREG     = 32,
    parameter logic [DW-1:0] RESET_PC = '0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [31:0]   instr_F,
    output logic [DW-1:0] PC_F,
    output logic [31:0]   instr_D,
    input  logic          RegWrite_D,
    input  logic          MemtoReg_D,
    input  logic          MemWrite_D,
    input  logic          MemRead_D,
    input  logic          ALUSrc_D,
    input  logic          RegDst_D,
    input  logic          Branch_D,
    input  logic          Jump_D,
    input  logic [2:0]    ALUControl_D,
    output logic [DW-1:0] ALUResult_M,
    output logic [DW-1:0] WriteData_M,
    output logic          MemWrite_M,
    output logic          MemRead_M,
    input  logic [DW-1:0] ReadData_M,
    input  logic          dmem_ready_M,
    output logic          stall_o
);

    localparam int AW = $clog2(NREG);

    logic [DW-1:0] r_pc_F, r_pc4_D;
    logic [31:0]   r_instr_D;
    ctrl_t         r_ctrl_E;
    logic [DW-1:0] r_rd1_E, r_rd2_E, r_imm_E;
    logic [AW-1:0] r_rs_E, r_rt_E, r_rd_E;
    logic          r_reg_write_M, r_mem_to_reg_M, r_mem_write_M, r_mem_read_M;
    logic [DW-1:0] r_alu_M, r_wd_M;
    logic [AW-1:0] r_wreg_M;
    logic          r_reg_write_W, r_mem_to_reg_W;
    logic [DW-1:0] r_alu_W, r_rdata_W;
    logic [AW-1:0] r_wreg_W;
    logic [DW-1:0] r_rf [NREG];

    ctrl_t         w_ctrl_D;
    logic [AW-1:0] w_rs_D, w_rt_D, w_rd_D, w_wreg_E;
    logic [DW-1:0] w_rf_a_D, w_rf_b_D, w_cmp_a_D, w_cmp_b_D, w_imm_D;
    logic [DW-1:0] w_pc4_F, w_btgt_D, w_jtgt_D, w_pc_next;
    logic [DW-1:0] w_src_a_E, w_src_b_E, w_alu_b_E, w_alu_E, w_result_W;
    logic [1:0]    w_fwd_a_E, w_fwd_b_E;
    logic          w_fwd_a_D, w_fwd_b_D, w_eq_D;
    logic          w_mem_wait, w_hold_F, w_bubble_E, w_redirect_D;

    assign w_ctrl_D = {RegWrite_D, MemtoReg_D, MemWrite_D, MemRead_D, ALUSrc_D, RegDst_D, ALUControl_D};
    assign w_rs_D   = r_instr_D[21 +: AW];
    assign w_rt_D   = r_instr_D[16 +: AW];
    assign w_rd_D   = r_instr_D[11 +: AW];
    assign w_imm_D  = {{(DW-16){r_instr_D[15]}}, r_instr_D[15:0]};

    assign w_result_W = r_mem_to_reg_W ? r_rdata_W : r_alu_W;
    assign w_rf_a_D = (r_reg_write_W && r_wreg_W != '0 && r_wreg_W == w_rs_D) ? w_result_W : r_rf[w_rs_D];
    assign w_rf_b_D = (r_reg_write_W && r_wreg_W != '0 && r_wreg_W == w_rt_D) ? w_result_W : r_rf[w_rt_D];
    assign w_cmp_a_D = w_fwd_a_D ? r_alu_M : w_rf_a_D;
    assign w_cmp_b_D = w_fwd_b_D ? r_alu_M : w_rf_b_D;
    assign w_eq_D    = (w_cmp_a_D == w_cmp_b_D);

    assign w_pc4_F   = r_pc_F + DW'(4);
    assign w_btgt_D  = r_pc4_D + (w_imm_D << 2);
    assign w_jtgt_D  = {r_pc4_D[DW-1:28], r_instr_D[25:0], 2'b00};
    assign w_pc_next = !w_redirect_D ? w_pc4_F : (Jump_D ? w_jtgt_D : w_btgt_D);

    assign w_wreg_E  = r_ctrl_E.reg_dst ? r_rd_E : r_rt_E;
    assign w_src_a_E = (w_fwd_a_E == FWD_M) ? r_alu_M : (w_fwd_a_E == FWD_W) ? w_result_W : r_rd1_E;
    assign w_src_b_E = (w_fwd_b_E == FWD_M) ? r_alu_M : (w_fwd_b_E == FWD_W) ? w_result_W : r_rd2_E;
    assign w_alu_b_E = r_ctrl_E.alu_src ? r_imm_E : w_src_b_E;

    always_comb begin
        w_alu_E = '0;
        case (r_ctrl_E.alu_ctrl)
            ALU_ADD: w_alu_E = w_src_a_E + w_alu_b_E;
            ALU_SUB: w_alu_E = w_src_a_E - w_alu_b_E;
            ALU_AND: w_alu_E = w_src_a_E & w_alu_b_E;
            ALU_OR:  w_alu_E = w_src_a_E | w_alu_b_E;
            ALU_SLT: w_alu_E = ($signed(w_src_a_E) < $signed(w_alu_b_E)) ? DW'(1) : '0;
            default: w_alu_E = '0;
        endcase
    end

    pipe_hazard #(.AW(AW)) u_hazard (
        .i_rs_D        (w_rs_D),
        .i_rt_D        (w_rt_D),
        .i_rs_E        (r_rs_E),
        .i_rt_E        (r_rt_E),
        .i_wreg_E      (w_wreg_E),
        .i_wreg_M      (r_wreg_M),
        .i_wreg_W      (r_wreg_W),
        .i_branch_D    (Branch_D),
        .i_jump_D      (Jump_D),
        .i_eq_D        (w_eq_D),
        .i_reg_write_E (r_ctrl_E.reg_write),
        .i_mem_to_reg_E(r_ctrl_E.mem_to_reg),
        .i_reg_write_M (r_reg_write_M),
        .i_mem_to_reg_M(r_mem_to_reg_M),
        .i_mem_access_M(r_mem_write_M || r_mem_read_M),
        .i_reg_write_W (r_reg_write_W),
        .i_dmem_ready_M(dmem_ready_M),
        .o_fwd_a_E     (w_fwd_a_E),
        .o_fwd_b_E     (w_fwd_b_E),
        .o_fwd_a_D     (w_fwd_a_D),
        .o_fwd_b_D     (w_fwd_b_D),
        .o_mem_wait    (w_mem_wait),
        .o_hold_F      (w_hold_F),
        .o_bubble_E    (w_bubble_E),
        .o_redirect_D  (w_redirect_D)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (r_reg_write_W && r_wreg_W != '0) begin
            r_rf[r_wreg_W] <= w_result_W;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pc_F <= RESET_PC;
            {r_instr_D, r_pc4_D} <= '0;
            {r_ctrl_E, r_rd1_E, r_rd2_E, r_imm_E, r_rs_E, r_rt_E, r_rd_E} <= '0;
            {r_reg_write_M, r_mem_to_reg_M, r_mem_write_M, r_mem_read_M, r_alu_M, r_wd_M, r_wreg_M} <= '0;
            {r_reg_write_W, r_mem_to_reg_W, r_alu_W, r_rdata_W, r_wreg_W} <= '0;
        end else begin
            if (!w_hold_F) begin
                r_pc_F <= w_pc_next;
                if (w_redirect_D) {r_instr_D, r_pc4_D} <= '0;
                else              {r_instr_D, r_pc4_D} <= {instr_F, w_pc4_F};
            end
            // While waiting, W is drained into the bubble, so E keeps its forwarded operands.
            if (w_mem_wait) begin
                r_rd1_E <= w_src_a_E;
                r_rd2_E <= w_src_b_E;
            end else if (w_bubble_E) begin
                r_ctrl_E <= '0;
            end else begin
                {r_ctrl_E, r_rd1_E, r_rd2_E, r_imm_E} <= {w_ctrl_D, w_rf_a_D, w_rf_b_D, w_imm_D};
                {r_rs_E, r_rt_E, r_rd_E} <= {w_rs_D, w_rt_D, w_rd_D};
            end
            if (!w_mem_wait) begin
                {r_reg_write_M, r_mem_to_reg_M} <= {r_ctrl_E.reg_write, r_ctrl_E.mem_to_reg};
                {r_mem_write_M, r_mem_read_M}   <= {r_ctrl_E.mem_write, r_ctrl_E.mem_read};
                {r_alu_M, r_wd_M, r_wreg_M}     <= {w_alu_E, w_src_b_E, w_wreg_E};
            end
            if (w_mem_wait) begin
                {r_reg_write_W, r_mem_to_reg_W} <= 2'b00;
            end else begin
                {r_reg_write_W, r_mem_to_reg_W} <= {r_reg_write_M, r_mem_to_reg_M};
                {r_alu_W, r_rdata_W, r_wreg_W}  <= {r_alu_M, ReadData_M, r_wreg_M};
            end
        end
    end

    assign PC_F        = r_pc_F;
    assign instr_D     = r_instr_D;
    assign ALUResult_M = r_alu_M;
    assign WriteData_M = r_wd_M;
    assign MemWrite_M  = r_mem_write_M;
    assign MemRead_M   = r_mem_read_M;
    assign stall_o     = w_hold_F;

endmodule
